periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter_if.sv | 50 +++++
 rtl/periph_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// ============================================================================
// periph_bus_arbiter_if
// Two-master / one-peripheral bus bundle; slave = arbiter side.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface periph_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [31:0]       m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [31:0]       m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] p_addr;
  logic              p_wr;
  logic [31:0]       p_wdata;
  logic [31:0]       p_rdata;

  logic              grant;
  logic              busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  p_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output p_addr, p_wr, p_wdata, grant, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output p_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  p_addr, p_wr, p_wdata, grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
// ============================================================================
// periph_bus_arbiter
// Arbitrates CPU (m0) and debug loader (m1) onto one peripheral register bus.
// Optional macro: ARB_ROUND_ROBIN_EN (round-robin on contention, else m0 wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module periph_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  periph_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_grant;
  logic              r_busy;
  logic [ADDR_W-1:0] r_p_addr;
  logic              r_p_wr;
  logic [31:0]       r_p_wdata;
  logic [31:0]       r_m0_rdata;
  logic [31:0]       r_m1_rdata;
  logic              r_m0_ack;
  logic              r_m1_ack;

  logic              w_any_req;
  logic              w_winner;
  logic [ADDR_W-1:0] w_win_addr;
  logic [31:0]       w_win_wdata;
  logic              w_win_wr;

  assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention the master that did not win last time goes first.
  always_comb begin
    w_winner = ~bus.m0_req;
    if (bus.m0_req && bus.m1_req) begin
      w_winner = ~r_last_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_grant <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = ~bus.m0_req;
  end
`endif

  assign w_win_addr  = w_winner ? bus.m1_addr  : bus.m0_addr;
  assign w_win_wdata = w_winner ? bus.m1_wdata : bus.m0_wdata;
  assign w_win_wr    = w_winner ? bus.m1_wr    : bus.m0_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_busy     <= 1'b0;
      r_p_addr   <= '0;
      r_p_wr     <= 1'b0;
      r_p_wdata  <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= ACCESS;
            r_grant   <= w_winner;
            r_busy    <= 1'b1;
            r_p_addr  <= w_win_addr;
            r_p_wdata <= w_win_wdata;
            r_p_wr    <= w_win_wr;
          end
        end
        ACCESS: begin
          // Single write strobe; peripheral read data sampled on the same edge.
          r_state <= ACK;
          r_p_wr  <= 1'b0;
          if (r_grant) begin
            r_m1_rdata <= bus.p_rdata;
          end else begin
            r_m0_rdata <= bus.p_rdata;
          end
          r_m0_ack <= ~r_grant;
          r_m1_ack <= r_grant;
        end
        ACK: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_p_addr  <= '0;
          r_p_wdata <= '0;
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.p_addr   = r_p_addr;
  assign bus.p_wr     = r_p_wr;
  assign bus.p_wdata  = r_p_wdata;
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m1_rdata = r_m1_rdata;
  assign bus.m0_ack   = r_m0_ack;
  assign bus.m1_ack   = r_m1_ack;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// ============================================================================
// tb_periph_bus_arbiter
// Scoreboard bench: expected transactions queued at issue, checked on ack.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_periph_bus_arbiter;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt   = 0;
  exp_t exp_q[$];

  periph_bus_arbiter_if #(.ADDR_W(32)) bus ();

  periph_bus_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] periph(input logic [31:0] a);
    if (a == 32'd1) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb bus.p_rdata = periph(bus.p_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = a;
    e.data = wr ? wd : periph(a);
    return e;
  endfunction

  function automatic exp_t mk_stream(input bit m, input int k);
    logic [31:0] kk;
    kk = k;
    return mk(m, kk[0], (m ? 32'h200 : 32'h100) + kk, 32'hC0DE_0000 | ({31'd0, m} << 8) | kk);
  endfunction

  // Monitor: write strobes and acks are compared against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (!bus.busy) chk("idle_paddr", bus.p_addr, 32'd0);
      if (bus.p_wr) begin
        wr_cnt++;
        chk("pwr_busy", {31'd0, bus.busy}, 32'd1);
        chk("pwr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("pwr_addr", bus.p_addr, exp_q[0].addr);
          chk("pwr_wdata", bus.p_wdata, exp_q[0].data);
          chk("pwr_grant", {31'd0, bus.grant}, {31'd0, exp_q[0].m});
        end
      end
      if (bus.m0_ack || bus.m1_ack) begin
        chk("ack_onehot", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
        chk("ack_no_pwr", {31'd0, bus.p_wr}, 32'd0);
        chk("ack_busy", {31'd0, bus.busy}, 32'd1);
        chk("ack_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_master", {31'd0, bus.m1_ack}, {31'd0, e.m});
          chk("ack_grant", {31'd0, bus.grant}, {31'd0, e.m});
          chk("ack_paddr", bus.p_addr, e.addr);
          chk("wr_pulses", wr_cnt, {31'd0, e.wr});
          if (!e.wr) chk("rdata", e.m ? bus.m1_rdata : bus.m0_rdata, e.data);
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic drive(input bit m, input bit req, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    if (m) begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = wd;
    end else begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = wd;
    end
  endtask

  // Issue one request and wait (bounded) for its ack; lat counts negedges.
  task automatic txn(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input bit keep, output int lat);
    logic ackd;
    drive(m, 1'b1, wr, a, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      ackd = m ? bus.m1_ack : bus.m0_ack;
    end while (!ackd && lat < 40);
    chk("ack_timeout", {31'd0, ackd}, 32'd1);
    if (!keep) drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic stream(input bit m, input int n, input bit chk_interval);
    exp_t e;
    int   lat;
    for (int k = 0; k < n; k++) begin
      e = mk_stream(m, k);
      txn(m, e.wr, e.addr, e.wr ? e.data : 32'h0, k != n - 1, lat);
      if (chk_interval && k > 0) chk("ack_interval", lat, 32'd3);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, {31'd0, bus.grant}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_pwr"}, {31'd0, bus.p_wr}, 32'd0);
    chk({tag, "_paddr"}, bus.p_addr, 32'd0);
    chk({tag, "_pwdata"}, bus.p_wdata, 32'd0);
    chk({tag, "_acks"}, {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    chk({tag, "_m0_rdata"}, bus.m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, bus.m1_rdata, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] saved;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_start_after_rst", {31'd0, bus.busy}, 32'd0);

    // Single m0 write: ack on the second negedge after issue.
    exp_q.push_back(mk(1'b0, 1'b1, 32'd0, 32'h0000_03FF));
    txn(1'b0, 1'b1, 32'd0, 32'h0000_03FF, 1'b0, lat);
    chk("ack_latency", lat, 32'd2);

    exp_q.push_back(mk(1'b0, 1'b0, 32'd5, 32'd0));
    txn(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, lat);
    @(negedge clk);

    // m0 requests continuously while m1 is idle.
    for (int k = 0; k < 5; k++) exp_q.push_back(mk_stream(1'b0, k));
    stream(1'b0, 5, 1'b1);
    @(negedge clk);

    saved = bus.m0_rdata;
    exp_q.push_back(mk(1'b1, 1'b0, 32'd1, 32'd0));
    txn(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, lat);
    chk("m1_rdata_beef", bus.m1_rdata, 32'hDEADBEEF);
    chk("m0_rdata_hold", bus.m0_rdata, saved);
    @(negedge clk);

    // Both masters contend for four transactions each.
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk_stream(1'b0, k));
      exp_q.push_back(mk_stream(1'b1, k));
    end
`else
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_stream(1'b0, k));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_stream(1'b1, k));
`endif
    fork
      stream(1'b0, 4, 1'b0);
      stream(1'b1, 4, 1'b0);
    join
    @(negedge clk);
    chk("contend_drain", exp_q.size(), 32'd0);

    // Reset in the ACCESS cycle of an m1 write aborts it.
    exp_q.push_back(mk(1'b1, 1'b1, 32'h44, 32'h1234_5678));
    drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h1234_5678);
    @(negedge clk);
    chk("abort_in_access", {31'd0, bus.p_wr}, 32'd1);
    #2 rst = 1'b1;
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 check_reset_vals("abort");
    repeat (2) @(negedge clk);
    chk("abort_no_ack", {31'd0, bus.m1_ack}, 32'd0);
    chk("abort_no_pwr", {31'd0, bus.p_wr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);

    exp_q.push_back(mk(1'b1, 1'b1, 32'h44, 32'h1234_5678));
    txn(1'b1, 1'b1, 32'h44, 32'h1234_5678, 1'b0, lat);
    chk("reissue_latency", lat, 32'd2);
    repeat (2) @(negedge clk);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
